// File: rtl/mem_map_pkg.sv
// MIPS memory-map constants and the syncram master state type.
// Shared by the bus master, its address decoder and later cache/MMIO logic.
package mem_map_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } smaster_state_t;

  localparam logic [31:0] MM_TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] MM_TEXT_SIZE = 32'h0000_1000;
  localparam logic [31:0] MM_DATA_BASE = 32'h1000_0000;
  localparam logic [31:0] MM_DATA_SIZE = 32'h0000_1000;
  localparam int          MM_RD_LAT    = 1;

endpackage

// File: rtl/syncram_master_if.sv
// Request/response handshakes plus the RAM port of the syncram master.
// master = the controller itself, slave = requester and RAM side.
interface syncram_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_cs;
  logic              mem_oe;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_cs, mem_oe, mem_we, mem_addr, mem_din
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_cs, mem_oe, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_addr_decode.sv
// Combinational memory-map check: region hits, alignment, and write-to-text.
// Region test is an unsigned offset compare so addresses below a base wrap and miss.
module mem_addr_decode
  import mem_map_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] TEXT_BASE = ADDR_W'(MM_TEXT_BASE),
  parameter logic [ADDR_W-1:0] TEXT_SIZE = ADDR_W'(MM_TEXT_SIZE),
  parameter logic [ADDR_W-1:0] DATA_BASE = ADDR_W'(MM_DATA_BASE),
  parameter logic [ADDR_W-1:0] DATA_SIZE = ADDR_W'(MM_DATA_SIZE)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  output logic              hit_text,
  output logic              hit_data,
  output logic              misaligned,
  output logic              err
);
  logic [ADDR_W-1:0] text_off;
  logic [ADDR_W-1:0] data_off;

  assign text_off   = addr - TEXT_BASE;
  assign data_off   = addr - DATA_BASE;
  assign hit_text   = (text_off < TEXT_SIZE);
  assign hit_data   = (data_off < DATA_SIZE);
  assign misaligned = (addr[1:0] != 2'b00);
  assign err        = misaligned | ~(hit_text | hit_data) | (we & hit_text);
endmodule

// File: rtl/syncram_master.sv
// Single-outstanding bus master for the syncram port: decode, one-cycle access,
// RD_LAT-cycle read wait, then a held response until the consumer accepts it.
module syncram_master
  import mem_map_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                RD_LAT    = MM_RD_LAT,
  parameter logic [ADDR_W-1:0] TEXT_BASE = ADDR_W'(MM_TEXT_BASE),
  parameter logic [ADDR_W-1:0] TEXT_SIZE = ADDR_W'(MM_TEXT_SIZE),
  parameter logic [ADDR_W-1:0] DATA_BASE = ADDR_W'(MM_DATA_BASE),
  parameter logic [ADDR_W-1:0] DATA_SIZE = ADDR_W'(MM_DATA_SIZE)
) (
  input  logic              clk,
  input  logic              rst_b,
  syncram_master_if.master  bus
);
  localparam int CNT_W = 3;

  smaster_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              dec_hit_text, dec_hit_data, dec_misaligned, dec_flag_err;
  logic              dec_err;
  logic              accept;

  mem_addr_decode #(
    .ADDR_W(ADDR_W), .TEXT_BASE(TEXT_BASE), .TEXT_SIZE(TEXT_SIZE),
    .DATA_BASE(DATA_BASE), .DATA_SIZE(DATA_SIZE)
  ) u_decode (
    .addr(bus.req_addr), .we(bus.req_we),
    .hit_text(dec_hit_text), .hit_data(dec_hit_data),
    .misaligned(dec_misaligned), .err(dec_flag_err)
  );

  assign dec_err = dec_flag_err | dec_misaligned | ~(dec_hit_text | dec_hit_data);
  assign accept  = (state_q == ST_IDLE) & bus.req_valid;

  always_ff @(posedge clk) begin
    if (!rst_b) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.req_valid) state_d = dec_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_d = we_q ? ST_RESP : ST_WAIT;
      ST_WAIT:   if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      ST_RESP:   if (bus.resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // mem_addr only moves on a decoded-good accept, so errors never disturb the RAM port
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        wdata_q <= bus.req_wdata;
        if (dec_err) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else begin
          addr_q  <= bus.req_addr;
        end
      end
      if (state_q == ST_ACCESS) begin
        if (we_q) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end else begin
          cnt_q   <= CNT_W'(RD_LAT);
        end
      end
      if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rdata_q <= bus.mem_dout;
          err_q   <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.req_ready  = (state_q == ST_IDLE);
    bus.resp_valid = (state_q == ST_RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    bus.mem_cs     = (state_q == ST_ACCESS) | (state_q == ST_WAIT);
    bus.mem_oe     = ((state_q == ST_ACCESS) & ~we_q) | (state_q == ST_WAIT);
    bus.mem_we     = (state_q == ST_ACCESS) & we_q;
    bus.mem_addr   = addr_q;
    bus.mem_din    = ((state_q == ST_ACCESS) & we_q) ? wdata_q : '0;
  end
endmodule

// File: tb/tb_syncram_master.sv
// Four syncram_master lanes (RD_LAT = 1..4), each with a latency-pipelined RAM model;
// a negedge monitor pops expected responses from per-lane queues.
module tb_syncram_master;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic clk = 1'b0;
  logic rst_b;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0]       req_valid, req_we, resp_ready;
  logic [3:0][31:0] req_addr, req_wdata;
  wire  [3:0]       req_ready, resp_valid, resp_err, mem_cs, mem_oe, mem_we;
  wire  [3:0][31:0] resp_rdata, mem_addr, mem_din;

  resp_t exp_q [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    syncram_master_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    logic [31:0] ram [2048];
    logic [31:0] pipe [4];
    wire  [10:0] idx = {mem_addr[g][28], mem_addr[g][11:2]};

    assign bus.req_valid  = req_valid[g];
    assign bus.req_we     = req_we[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.req_wdata  = req_wdata[g];
    assign bus.resp_ready = resp_ready[g];
    assign bus.mem_dout   = pipe[g];
    assign req_ready[g]   = bus.req_ready;
    assign resp_valid[g]  = bus.resp_valid;
    assign resp_rdata[g]  = bus.resp_rdata;
    assign resp_err[g]    = bus.resp_err;
    assign mem_cs[g]      = bus.mem_cs;
    assign mem_oe[g]      = bus.mem_oe;
    assign mem_we[g]      = bus.mem_we;
    assign mem_addr[g]    = bus.mem_addr;
    assign mem_din[g]     = bus.mem_din;

    syncram_master #(.RD_LAT(g + 1)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

    initial begin
      for (int i = 0; i < 1024; i++) begin
        ram[i]        = (32'h0040_0000 + 32'(i) * 4) ^ 32'hDEAD_0000;
        ram[1024 + i] = (32'h1000_0000 + 32'(i) * 4) ^ 32'hBEEF_0000;
      end
    end

    always @(posedge clk) begin
      if (mem_cs[g] && mem_we[g]) ram[idx] <= mem_din[g];
      pipe[0] <= ram[idx];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    resp_t e;
    for (int l = 0; l < 4; l++) begin
      if (rst_b && resp_valid[l] && resp_ready[l]) begin
        if (exp_q[l].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp lane %0d: got %h expected none", l, resp_rdata[l]);
        end else begin
          e = exp_q[l].pop_front();
          chk($sformatf("resp_rdata lane%0d", l), resp_rdata[l], e.rdata);
          chk($sformatf("resp_err lane%0d", l), 32'(resp_err[l]), 32'(e.err));
        end
      end
    end
  end

  // elat = cycles from the accept edge to resp_valid; cs is high for exactly that many cycles
  task automatic do_txn(input int ln, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] erd, input bit eerr, input int elat);
    int acc, n, ncs, nwe, noe;
    exp_q[ln].push_back('{rdata: erd, err: eerr});
    req_we[ln] = we; req_addr[ln] = a; req_wdata[ln] = wd; req_valid[ln] = 1'b1;
    n = 0;
    while (!req_ready[ln] && n < 40) begin step(); n++; end
    acc = cyc + 1;
    step();
    req_valid[ln] = 1'b0;
    ncs = 0; nwe = 0; noe = 0; n = 0;
    while (!resp_valid[ln] && n < 40) begin
      ncs += int'(mem_cs[ln]); nwe += int'(mem_we[ln]); noe += int'(mem_oe[ln]);
      step(); n++;
    end
    chk($sformatf("resp_seen %h", a), 32'(resp_valid[ln]), 32'd1);
    chk($sformatf("latency %h", a), 32'(cyc - acc), 32'(elat));
    chk($sformatf("cs_cycles %h", a), 32'(ncs), 32'(elat));
    chk($sformatf("we_cycles %h", a), 32'(nwe), (we && !eerr) ? 32'd1 : 32'd0);
    chk($sformatf("oe_cycles %h", a), 32'(noe), (!we && !eerr) ? 32'(elat) : 32'd0);
    step();
  endtask

  task automatic sweep(input int ln);
    int t1, t2, acc, n;
    exp_q[ln].push_back('{rdata: 32'hDEED_0020, err: 1'b0});
    exp_q[ln].push_back('{rdata: 32'hDEED_002C, err: 1'b0});
    req_we[ln] = 1'b0; req_addr[ln] = 32'h0040_0020; req_valid[ln] = 1'b1;
    n = 0;
    while (!req_ready[ln] && n < 40) begin step(); n++; end
    acc = cyc + 1;
    step();
    req_addr[ln] = 32'h0040_002C;
    n = 0;
    while (!resp_valid[ln] && n < 40) begin step(); n++; end
    t1 = cyc;
    chk($sformatf("sweep_lat lane%0d", ln), 32'(t1 - acc), 32'(ln + 2));
    step();
    step();
    req_valid[ln] = 1'b0;
    n = 0;
    while (!resp_valid[ln] && n < 40) begin step(); n++; end
    t2 = cyc;
    chk($sformatf("sweep_spacing lane%0d", ln), 32'(t2 - t1), 32'(ln + 4));
    step();
  endtask

  initial begin
    rst_b = 1'b0; req_valid = '0; req_we = '0; resp_ready = '1;
    req_addr = '0; req_wdata = '0;
    repeat (3) step();
    chk("rst req_ready", 32'(req_ready), 32'hF);
    chk("rst resp_valid", 32'(resp_valid), 32'h0);
    chk("rst mem_cs", 32'(mem_cs), 32'h0);
    chk("rst mem_addr", mem_addr[0], 32'h0);
    rst_b = 1'b1;
    step();

    do_txn(0, 1'b0, 32'h0040_0050, 32'h0, 32'hDEED_0050, 1'b0, 2);
    do_txn(0, 1'b1, 32'h1000_0024, 32'h7, 32'h0,         1'b0, 1);
    do_txn(0, 1'b0, 32'h1000_0024, 32'h0, 32'h7,         1'b0, 2);
    do_txn(0, 1'b1, 32'h0040_003C, 32'h55, 32'h0,        1'b1, 0);
    do_txn(0, 1'b0, 32'h1000_0026, 32'h0, 32'h0,         1'b1, 0);
    do_txn(0, 1'b0, 32'h2000_0000, 32'h0, 32'h0,         1'b1, 0);
    do_txn(0, 1'b0, 32'h1000_0FFC, 32'h0, 32'hAEEF_0FFC, 1'b0, 2);
    do_txn(0, 1'b0, 32'h1000_1000, 32'h0, 32'h0,         1'b1, 0);
    do_txn(0, 1'b0, 32'h003F_FFFC, 32'h0, 32'h0,         1'b1, 0);

    // backpressure: stray requests during the held response must be dropped
    resp_ready[0] = 1'b0;
    do_txn(0, 1'b0, 32'h0040_0050, 32'h0, 32'hDEED_0050, 1'b0, 2);
    for (int i = 0; i < 5; i++) begin
      req_valid[0] = i[0]; req_we[0] = 1'b1;
      req_addr[0] = 32'h1000_0000; req_wdata[0] = 32'h0000_0BAD;
      chk("bp resp_valid", 32'(resp_valid[0]), 32'd1);
      chk("bp resp_rdata", resp_rdata[0], 32'hDEED_0050);
      chk("bp resp_err", 32'(resp_err[0]), 32'd0);
      chk("bp req_ready", 32'(req_ready[0]), 32'd0);
      chk("bp mem_cs", 32'(mem_cs[0]), 32'd0);
      step();
    end
    req_valid[0] = 1'b0; resp_ready[0] = 1'b1;
    step();
    do_txn(0, 1'b0, 32'h1000_0000, 32'h0, 32'hAEEF_0000, 1'b0, 2);

    // reset in the middle of a RD_LAT=3 read
    req_we[2] = 1'b0; req_addr[2] = 32'h0040_0020; req_valid[2] = 1'b1;
    for (int n = 0; n < 40 && !req_ready[2]; n++) step();
    step();
    req_valid[2] = 1'b0;
    step();
    chk("mid mem_cs", 32'(mem_cs[2]), 32'd1);
    step();
    rst_b = 1'b0;
    step();
    chk("rstmid req_ready", 32'(req_ready[2]), 32'd1);
    chk("rstmid resp_valid", 32'(resp_valid[2]), 32'd0);
    chk("rstmid resp_err", 32'(resp_err[2]), 32'd0);
    chk("rstmid resp_rdata", resp_rdata[2], 32'h0);
    chk("rstmid mem_ctl", {29'd0, mem_cs[2], mem_oe[2], mem_we[2]}, 32'h0);
    chk("rstmid mem_addr", mem_addr[2], 32'h0);
    chk("rstmid mem_din", mem_din[2], 32'h0);
    rst_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("rstmid no_resp", 32'(resp_valid[2]), 32'd0);
      step();
    end
    do_txn(2, 1'b0, 32'h0040_002C, 32'h0, 32'hDEED_002C, 1'b0, 4);

    sweep(0);
    sweep(1);
    sweep(3);

    for (int l = 0; l < 4; l++)
      chk($sformatf("queue_empty lane%0d", l), 32'(exp_q[l].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
